// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared types and constants for the raster timing block.
// Holds the sequencer state enum, the test-pattern selector enum, the 720p60
// default timing set and the colour-bar RGB table.
package video_timing_pkg;

    // Sequencer states: IDLE holds everything at zero, RUN counts, DRAIN counts
    // until the current frame ends.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Test-pattern selector encoding (only used when the pattern generator is built).
    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_WHITE   = 2'd3
    } pattern_e;

    // 1280x720 @ 60 Hz timing.
    localparam int H_ACTIVE_720 = 1280;
    localparam int H_FP_720     = 110;
    localparam int H_SYNC_720   = 40;
    localparam int H_BP_720     = 220;
    localparam int V_ACTIVE_720 = 720;
    localparam int V_FP_720     = 5;
    localparam int V_SYNC_720   = 5;
    localparam int V_BP_720     = 20;
    localparam int FPS_720      = 60;

    // Counter widths are fixed by the output ports.
    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int FCOUNT_W = 6;

    // Colour bars left to right: index 0 is the leftmost bar (white).
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000,   // 7 black
        24'h0000FF,   // 6 blue
        24'hFF0000,   // 5 red
        24'hFF00FF,   // 4 magenta
        24'h00FF00,   // 3 green
        24'h00FFFF,   // 2 cyan
        24'hFFFF00,   // 1 yellow
        24'hFFFFFF    // 0 white
    };

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH x WIDTH shift register with synchronous active-high
// reset. DEPTH = 0 degenerates to a combinational pass-through.
module sync_delay_line
    import video_timing_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    if (DEPTH == 0) begin : g_pass
        // Clock and reset have no job in the pass-through form.
        logic w_unused_ctrl;
        assign w_unused_ctrl = i_clk ^ i_rst;
        assign o_data        = i_data;
    end else begin : g_shift
        logic [WIDTH-1:0] r_stage [DEPTH];

        // Shift the sync bundle one stage per clock; reset clears every stage.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_stage[i] <= '0;
                end
            end else begin
                r_stage[0] <= i_data;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_data = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: pixel-clock raster sequencer (hcount/vcount, syncs,
// active_draw, new_frame, frame_count) with an IDLE/RUN/DRAIN start-stop FSM
// that only stops on a frame boundary, plus PIPE_DELAY-delayed sync copies.
// Optional macro TEST_PATTERN_EN adds pattern_sel and a registered RGB
// test-pattern generator.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_720,
    parameter int H_FP       = H_FP_720,
    parameter int H_SYNC     = H_SYNC_720,
    parameter int H_BP       = H_BP_720,
    parameter int V_ACTIVE   = V_ACTIVE_720,
    parameter int V_FP       = V_FP_720,
    parameter int V_SYNC     = V_SYNC_720,
    parameter int V_BP       = V_BP_720,
    parameter int FPS        = FPS_720,
    parameter int PIPE_DELAY = 4
) (
    input  logic                clk_pixel,
    input  logic                sys_rst_pixel,
    input  logic                enable,
`ifdef TEST_PATTERN_EN
    input  logic [1:0]          pattern_sel,
    output logic [7:0]          red,
    output logic [7:0]          green,
    output logic [7:0]          blue,
`endif
    output logic [HCOUNT_W-1:0] hcount,
    output logic [VCOUNT_W-1:0] vcount,
    output logic                active_draw,
    output logic                hsync,
    output logic                vsync,
    output logic                new_frame,
    output logic [FCOUNT_W-1:0] frame_count,
    output logic                running,
    output logic                hsync_hdmi,
    output logic                vsync_hdmi,
    output logic                active_draw_hdmi
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // A timing set that does not fit the port widths cannot be built.
    if ((H_TOTAL > (1 << HCOUNT_W)) || (V_TOTAL > (1 << VCOUNT_W)) ||
        (FPS < 1) || (FPS > (1 << FCOUNT_W))) begin : g_cfg_error
        $error("video_timing_ctrl: timing totals or FPS exceed counter widths");
    end

    localparam logic [HCOUNT_W-1:0] H_LAST  = HCOUNT_W'(H_TOTAL - 1);
    localparam logic [HCOUNT_W-1:0] H_ACT   = HCOUNT_W'(H_ACTIVE);
    localparam logic [HCOUNT_W-1:0] H_SS    = HCOUNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCOUNT_W-1:0] H_SE    = HCOUNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCOUNT_W-1:0] V_LAST  = VCOUNT_W'(V_TOTAL - 1);
    localparam logic [VCOUNT_W-1:0] V_ACT   = VCOUNT_W'(V_ACTIVE);
    localparam logic [VCOUNT_W-1:0] V_SS    = VCOUNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCOUNT_W-1:0] V_SE    = VCOUNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [FCOUNT_W-1:0] FC_LAST = FCOUNT_W'(FPS - 1);

    state_e                r_state;
    logic [HCOUNT_W-1:0]   r_hcount;
    logic [VCOUNT_W-1:0]   r_vcount;
    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_active;
    logic                  r_new_frame;
    logic [FCOUNT_W-1:0]   r_frame_count;
    logic                  r_running;

    state_e                w_next_state;
    logic [HCOUNT_W-1:0]   w_next_h;
    logic [VCOUNT_W-1:0]   w_next_v;
    logic                  w_at_last;
    logic                  w_run_n;
    logic                  w_hsync_n;
    logic                  w_vsync_n;
    logic                  w_active_n;
    logic                  w_new_frame_n;
    logic [2:0]            w_hdmi;

    assign w_at_last = (r_hcount == H_LAST) && (r_vcount == V_LAST);

    // Next state and next raster position; outputs are decoded from these so
    // every registered output lines up with the hcount/vcount it is shown with.
    always_comb begin
        w_next_state = IDLE;
        w_next_h     = '0;
        w_next_v     = '0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN, DRAIN: begin
                if (w_at_last) begin
                    // Frame boundary: keep going only if still requested.
                    if (enable) begin
                        w_next_state = RUN;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else begin
                    if (enable) begin
                        w_next_state = RUN;
                    end else begin
                        w_next_state = DRAIN;
                    end
                    if (r_hcount == H_LAST) begin
                        w_next_v = r_vcount + VCOUNT_W'(1);
                    end else begin
                        w_next_h = r_hcount + HCOUNT_W'(1);
                        w_next_v = r_vcount;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_run_n       = (w_next_state != IDLE);
    assign w_hsync_n     = w_run_n && (w_next_h >= H_SS) && (w_next_h < H_SE);
    assign w_vsync_n     = w_run_n && (w_next_v >= V_SS) && (w_next_v < V_SE);
    assign w_active_n    = w_run_n && (w_next_h < H_ACT) && (w_next_v < V_ACT);
    assign w_new_frame_n = w_run_n && (w_next_h == H_ACT) && (w_next_v == V_ACT);

    // Sequencer FSM, raster counters and registered timing outputs.
    always_ff @(posedge clk_pixel) begin
        if (sys_rst_pixel) begin
            r_state       <= IDLE;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_active      <= 1'b0;
            r_new_frame   <= 1'b0;
            r_frame_count <= '0;
            r_running     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_hcount    <= w_next_h;
            r_vcount    <= w_next_v;
            r_hsync     <= w_hsync_n;
            r_vsync     <= w_vsync_n;
            r_active    <= w_active_n;
            r_new_frame <= w_new_frame_n;
            r_running   <= w_run_n;
            if (w_new_frame_n) begin
                if (r_frame_count == FC_LAST) begin
                    r_frame_count <= '0;
                end else begin
                    r_frame_count <= r_frame_count + FCOUNT_W'(1);
                end
            end else begin
                r_frame_count <= r_frame_count;
            end
        end
    end

    sync_delay_line #(
        .DEPTH (PIPE_DELAY),
        .WIDTH (3)
    ) u_sync_delay (
        .i_clk  (clk_pixel),
        .i_rst  (sys_rst_pixel),
        .i_data ({r_hsync, r_vsync, r_active}),
        .o_data (w_hdmi)
    );

    assign hcount           = r_hcount;
    assign vcount           = r_vcount;
    assign active_draw      = r_active;
    assign hsync            = r_hsync;
    assign vsync            = r_vsync;
    assign new_frame        = r_new_frame;
    assign frame_count      = r_frame_count;
    assign running          = r_running;
    assign hsync_hdmi       = w_hdmi[2];
    assign vsync_hdmi       = w_hdmi[1];
    assign active_draw_hdmi = w_hdmi[0];

`ifdef TEST_PATTERN_EN
    localparam logic [HCOUNT_W-1:0] H_BAR_W = HCOUNT_W'(H_ACTIVE / 8);

    logic [2:0]  w_bar_idx;
    logic [23:0] w_rgb_n;
    logic [23:0] r_rgb;

    assign w_bar_idx = 3'(w_next_h / H_BAR_W);

    // Pattern pixel for the next raster position; black outside active video.
    always_comb begin
        w_rgb_n = 24'h000000;
        if (w_active_n) begin
            case (pattern_e'(pattern_sel))
                PAT_BARS:    w_rgb_n = BAR_RGB[w_bar_idx];
                PAT_RAMP:    w_rgb_n = {3{w_next_h[7:0]}};
                PAT_CHECKER: w_rgb_n = (w_next_h[5] ^ w_next_v[5]) ? 24'hFFFFFF : 24'h000000;
                PAT_WHITE:   w_rgb_n = 24'hFFFFFF;
                default:     w_rgb_n = 24'h000000;
            endcase
        end else begin
            w_rgb_n = 24'h000000;
        end
    end

    // Register the pattern pixel alongside the timing outputs.
    always_ff @(posedge clk_pixel) begin
        if (sys_rst_pixel) begin
            r_rgb <= 24'h000000;
        end else begin
            r_rgb <= w_rgb_n;
        end
    end

    assign red   = r_rgb[23:16];
    assign green = r_rgb[15:8];
    assign blue  = r_rgb[7:0];
`endif

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Pixel-clock-domain sequencer that produces raster timing (hcount/vcount, hsync, vsync, active_draw) for the HDMI output path, plus frame bookkeeping. It drives the sync and active-draw inputs of the TMDS encode/serialize stage and the pixel-fetch logic upstream of it. Delayed sync copies compensate for pixel-pipeline latency. A start/stop state machine ensures output only ever stops on a frame boundary.

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FP / H_SYNC / H_BP, 110 / 40 / 220, horizontal porches and sync width (H_TOTAL = 1650)
- V_ACTIVE, 720, active lines per frame
- V_FP / V_SYNC / V_BP, 5 / 5 / 20, vertical porches and sync width (V_TOTAL = 750)
- FPS, 60, frame_count modulus
- PIPE_DELAY, 4, cycles of delay on the *_hdmi outputs (0 allowed)
- clk_pixel  in  1  pixel clock; the block's only clock
- sys_rst_pixel  in  1  synchronous, active-high reset
- enable  in  1  request to run; sampled every cycle
- hcount  out  11  horizontal position, 0..H_TOTAL-1
- vcount  out  10  vertical position, 0..V_TOTAL-1
- active_draw  out  1  hcount < H_ACTIVE and vcount < V_ACTIVE, while running
- hsync / vsync  out  1  positive-polarity sync
- new_frame  out  1  single-cycle pulse at the start of vertical blank
- frame_count  out  6  counts new_frame pulses, 0..FPS-1
- running  out  1  high in RUN and DRAIN
- hsync_hdmi / vsync_hdmi / active_draw_hdmi  out  1  hsync/vsync/active_draw delayed by PIPE_DELAY

## Operation
- States:
  - IDLE: counters held at 0; hsync, vsync, active_draw and new_frame held low.
  - RUN: raster counting.
  - DRAIN: raster counting continues until the frame ends.
- Transitions:
  - IDLE→RUN when enable = 1.
  - RUN→DRAIN when enable = 0.
  - DRAIN→RUN when enable = 1; no discontinuity in counting.
  - DRAIN→IDLE on the last pixel (hcount = H_TOTAL-1, vcount = V_TOTAL-1).
  - RUN with enable = 1 at the last pixel wraps to 0,0.
- Counting:
  - hcount increments each cycle and wraps at H_TOTAL-1.
  - vcount increments on the hcount wrap and wraps at V_TOTAL-1.
- hsync = 1 for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync = 1 for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for the whole line.
- new_frame = 1 only when hcount = H_ACTIVE and vcount = V_ACTIVE, while running.
- frame_count increments on new_frame and wraps FPS-1→0. It is held, not cleared, in IDLE.
- All derived outputs are registered and aligned to the hcount/vcount values shown in the same cycle.
- Counter widths are fixed by the port widths; a parameter set whose totals exceed them is a configuration error, flagged by an elaboration-time assertion.

## Timing
- Reset: state = IDLE. All outputs, including frame_count and the delay lines, are 0.
- Reset mid-frame aborts immediately; there is no drain.
- Start: enable sampled high in IDLE at cycle N → cycle N+1 shows hcount = 0, vcount = 0, active_draw = 1, running = 1.
- Stop: the cycle after the last pixel of the frame in which enable fell shows running = 0, hcount = 0, active_draw = 0.
- *_hdmi outputs equal the undelayed signals from PIPE_DELAY cycles earlier. With PIPE_DELAY = 0 they are identical in the same cycle.
- Throughput: one pixel per clk_pixel; there is no backpressure.

## Configuration
- TEST_PATTERN_EN defined: adds input pattern_sel[1:0] and outputs red/green/blue[7:0].
  - Pixel values are registered and aligned with hcount/active_draw; all channels are 0 when active_draw = 0.
  - pattern_sel 0 = eight vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black; 0xFF/0x00 components).
  - pattern_sel 1 = grey ramp, all channels = hcount[7:0].
  - pattern_sel 2 = checkerboard, 0xFF when hcount[5]^vcount[5] else 0x00.
  - pattern_sel 3 = solid white.
- TEST_PATTERN_EN undefined: those ports and the pattern logic do not exist; all other behaviour is unchanged.

## Structure
- Package video_timing_pkg holds:
  - state enum {IDLE, RUN, DRAIN};
  - pattern_sel enum;
  - 720p default timing constants;
  - colour-bar RGB constant table.
- Sub-module sync_delay_line: parameterised DEPTH×WIDTH shift register with synchronous reset; DEPTH = 0 is a pass-through. It is instantiated once, with WIDTH = 3, for the *_hdmi outputs.

## Test plan
- Reset, then enable = 1 at cycle 10 → cycle 11: hcount = 0, vcount = 0, active_draw = 1; hsync first rises at hcount = 1390 and falls at 1430.
- Full frame at defaults → exactly one new_frame, at (1280, 720); vsync high for vcount 725..729 (5 × 1650 cycles); 921600 active_draw cycles.
- Drop enable mid-frame at (500, 300) → counting continues; running falls the cycle after (1649, 749); a 1-cycle enable pulse during DRAIN → stays in RUN with no glitch.
- PIPE_DELAY = 4 → hsync_hdmi/vsync_hdmi/active_draw_hdmi match hsync/vsync/active_draw delayed by exactly 4 cycles; PIPE_DELAY = 0 → identical.
- 61 frames → frame_count sequence 0..59, then 0, then 1; assert sys_rst_pixel at (100, 100) → next cycle all outputs 0, state IDLE.
- TEST_PATTERN_EN, pattern_sel = 0 → at hcount 0/160/1279, RGB = FFFFFF/FFFF00/000000; during blanking RGB = 0.
